// File: rtl/victim_way_sel.sv
// rtl/victim_way_sel.sv - random-replacement victim way selector for set-associative caches
module victim_way_sel #(
  parameter int WAYS = 4,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rand_byte,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [WAYS-1:0] req_valid_mask,
  input  logic [WAYS-1:0] req_lock_mask,
  output logic            victim_valid,
  output logic [WW-1:0]   victim_way,
  output logic            victim_was_invalid,
  output logic            victim_all_locked,
  input  logic            fill_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]      state;
  logic [WAYS-1:0] valid_q;
  logic [WAYS-1:0] lock_q;
  logic [WW-1:0]   last_victim;
  logic            last_valid;

  logic [WAYS-1:0] elig;
  logic [WAYS-1:0] inv;
  logic [WW-1:0]   c;
  logic [WW:0]     pc;
  logic            avoid;
  logic            found;
  logic [WW-1:0]   idx;
  logic [WW-1:0]   sel_way;
  logic            sel_inv;
  logic            sel_all;

  assign req_ready    = (state == IDLE);
  assign victim_valid = (state == HOLD);

  always_comb begin
    elig    = ~lock_q;
    inv     = elig & ~valid_q;
    c       = rand_byte[WW-1:0];
    pc      = '0;
    found   = 1'b0;
    idx     = '0;
    sel_way = c;
    sel_inv = 1'b0;
    sel_all = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      pc = pc + {{WW{1'b0}}, elig[i]};
    end
    // Avoiding the previous victim is only possible with a second eligible way.
    avoid = last_valid && (pc >= (WW+1)'(2));
    if (inv != '0) begin
      sel_inv = 1'b1;
      for (int i = 0; i < WAYS; i++) begin
        if (!found && inv[i]) begin
          sel_way = WW'(i);
          found   = 1'b1;
        end
      end
    end else if (elig == '0) begin
      sel_way = c;
      sel_all = 1'b1;
      sel_inv = !valid_q[c];
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        idx = c + WW'(i);
        if (!found && elig[idx] && !(avoid && (idx == last_victim))) begin
          sel_way = idx;
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      valid_q            <= '0;
      lock_q             <= '0;
      victim_way         <= '0;
      victim_was_invalid <= 1'b0;
      victim_all_locked  <= 1'b0;
      last_victim        <= '0;
      last_valid         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            valid_q <= req_valid_mask;
            lock_q  <= req_lock_mask;
            state   <= SEL;
          end
        end
        SEL: begin
          victim_way         <= sel_way;
          victim_was_invalid <= sel_inv;
          victim_all_locked  <= sel_all;
          state              <= HOLD;
        end
        HOLD: begin
          if (fill_done) begin
            last_victim <= victim_way;
            last_valid  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_way_sel.sv
// tb/tb_victim_way_sel.sv - directed self-checking bench for victim_way_sel
module tb_victim_way_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rand_byte;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_valid_mask;
  logic [3:0] req_lock_mask;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       victim_was_invalid;
  logic       victim_all_locked;
  logic       fill_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  victim_way_sel #(.WAYS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .rand_byte          (rand_byte),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_valid_mask     (req_valid_mask),
    .req_lock_mask      (req_lock_mask),
    .victim_valid       (victim_valid),
    .victim_way         (victim_way),
    .victim_was_invalid (victim_was_invalid),
    .victim_all_locked  (victim_all_locked),
    .fill_done          (fill_done)
  );

  // Drive a request, accept it, then scramble the masks; returns at the SEL-cycle negedge.
  task automatic accept(input logic [3:0] v, input logic [3:0] l, input logic [7:0] r);
    @(negedge clk);
    req_valid      = 1'b1;
    req_valid_mask = v;
    req_lock_mask  = l;
    rand_byte      = r;
    @(posedge clk);
    @(negedge clk);
    req_valid      = 1'b0;
    req_valid_mask = 4'h0;
    req_lock_mask  = 4'h5;
  endtask

  task automatic to_hold();
    @(posedge clk);
    @(negedge clk);
    rand_byte = 8'hA6;
  endtask

  task automatic fill();
    fill_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fill_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (victim_valid !== 1'b0) begin failures++; $display("FAIL reset_vvalid got=%b exp=0", victim_valid); end
    checks++; if (victim_way !== 2'd0) begin failures++; $display("FAIL reset_way got=%0d exp=0", victim_way); end
    checks++; if ({victim_was_invalid, victim_all_locked} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {victim_was_invalid, victim_all_locked}); end
    fill();
    checks++; if (req_ready !== 1'b1 || victim_valid !== 1'b0) begin failures++; $display("FAIL idle_fill_ignored got=%b%b exp=10", req_ready, victim_valid); end
  endtask

  task automatic test_invalid_first();
    accept(4'b1011, 4'b0000, 8'hFF);
    checks++; if (victim_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL inv_sel_cycle got=%b%b exp=00", victim_valid, req_ready); end
    to_hold();
    checks++; if (victim_valid !== 1'b1) begin failures++; $display("FAIL inv_latency got=%b exp=1", victim_valid); end
    checks++; if (victim_way !== 2'd2) begin failures++; $display("FAIL inv_way got=%0d exp=2", victim_way); end
    checks++; if (victim_was_invalid !== 1'b1 || victim_all_locked !== 1'b0) begin failures++; $display("FAIL inv_flags got=%b%b exp=10", victim_was_invalid, victim_all_locked); end
    fill();
    checks++; if (victim_valid !== 1'b0 || req_ready !== 1'b1 || victim_way !== 2'd2) begin failures++; $display("FAIL inv_release got=%b%b%0d exp=012", victim_valid, req_ready, victim_way); end
  endtask

  task automatic test_repeat_avoid();
    accept(4'hF, 4'h0, 8'h05);
    to_hold();
    checks++; if (victim_way !== 2'd1 || victim_was_invalid !== 1'b0) begin failures++; $display("FAIL rep_first got=%0d/%b exp=1/0", victim_way, victim_was_invalid); end
    fill();
    accept(4'hF, 4'h0, 8'h01);
    to_hold();
    checks++; if (victim_way !== 2'd2) begin failures++; $display("FAIL rep_avoid got=%0d exp=2", victim_way); end
    fill();
  endtask

  task automatic test_lock_skip();
    do_reset();
    accept(4'hF, 4'b0110, 8'h01);
    to_hold();
    checks++; if (victim_way !== 2'd3) begin failures++; $display("FAIL lock_way got=%0d exp=3", victim_way); end
    checks++; if (victim_all_locked !== 1'b0 || victim_was_invalid !== 1'b0) begin failures++; $display("FAIL lock_flags got=%b%b exp=00", victim_all_locked, victim_was_invalid); end
    fill();
  endtask

  task automatic test_all_locked();
    accept(4'hF, 4'hF, 8'h02);
    to_hold();
    checks++; if (victim_way !== 2'd2) begin failures++; $display("FAIL alllock_way got=%0d exp=2", victim_way); end
    checks++; if (victim_all_locked !== 1'b1 || victim_was_invalid !== 1'b0) begin failures++; $display("FAIL alllock_flags got=%b%b exp=10", victim_all_locked, victim_was_invalid); end
    fill();
  endtask

  task automatic test_reset_mid();
    accept(4'hF, 4'h0, 8'h03);
    to_hold();
    checks++; if (victim_way !== 2'd3) begin failures++; $display("FAIL mid_pre_way got=%0d exp=3", victim_way); end
    req_valid = 1'b1;
    req_valid_mask = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (victim_valid !== 1'b1 || victim_way !== 2'd3 || victim_was_invalid !== 1'b0) begin failures++; $display("FAIL hold_stable got=%b%0d%b exp=130", victim_valid, victim_way, victim_was_invalid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (victim_valid !== 1'b0 || req_ready !== 1'b1 || victim_way !== 2'd0) begin failures++; $display("FAIL mid_reset got=%b%b%0d exp=010", victim_valid, req_ready, victim_way); end
    accept(4'hF, 4'h0, 8'h03);
    to_hold();
    checks++; if (victim_way !== 2'd3 || victim_valid !== 1'b1) begin failures++; $display("FAIL mid_after got=%0d/%b exp=3/1", victim_way, victim_valid); end
    fill();
  endtask

  initial begin
    rst            = 1'b1;
    rand_byte      = 8'h00;
    req_valid      = 1'b0;
    req_valid_mask = 4'h0;
    req_lock_mask  = 4'h0;
    fill_done      = 1'b0;
    test_reset();
    test_invalid_first();
    test_repeat_avoid();
    test_lock_skip();
    test_all_locked();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/victim_way_sel.md
# victim_way_sel

Random-replacement victim selector for the set-associative caches. It consumes the 8-bit pseudo-random byte from the LFSR stage, together with the per-set valid and lock bits supplied by the cache controller on a miss. It returns a stable victim way that is held until the refill completes, and it sits between the LFSR and the cache refill FSM.

## Interface
- WAYS, 4, number of ways; power of 2, range 2..8. WW = log2(WAYS).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rand  in  8  pseudo-random byte from the LFSR; only rand[WW-1:0] is used.
- req_valid  in  1  miss request from the cache controller.
- req_ready  out  1  the block can accept a request; 1 only in IDLE.
- req_valid_mask  in  WAYS  valid bit of each way of the missed set.
- req_lock_mask  in  WAYS  1 = way is excluded from replacement.
- victim_valid  out  1  victim_way is valid and stable.
- victim_way  out  WW  selected way.
- victim_was_invalid  out  1  the selected way was not valid (no writeback needed).
- victim_all_locked  out  1  every way was locked; the selection is forced.
- fill_done  in  1  the refill FSM has finished with the victim.

## Operation
- FSM states: IDLE, SEL, HOLD.
  - IDLE -> SEL on req_valid && req_ready. req_valid_mask and req_lock_mask are captured into registers on this edge.
  - SEL -> HOLD unconditionally after 1 cycle. rand is sampled in SEL, and the victim is computed and registered.
  - HOLD -> IDLE on fill_done. Otherwise the block stays in HOLD.
- Eligible set: E = ~lock_q.
- Selection priority, evaluated in SEL:
  1. Invalid ways: if (E & ~valid_q) != 0, the victim is the lowest-index way in that set. victim_was_invalid = 1.
  2. Random pick: otherwise let c = rand[WW-1:0].
     - Repeat avoidance applies only when last_valid = 1 and popcount(E) >= 2. In that case, if c == last_victim, c is treated as rejected.
     - If c is ineligible or rejected, scan c+1, c+2, … modulo WAYS. Take the first way that is eligible and is not last_victim. The last_victim exclusion applies only under the same repeat-avoidance condition.
     - victim_was_invalid = 0.
  3. All locked: if E == 0, the victim is c unmodified, victim_all_locked = 1 and victim_was_invalid = !valid_q[c].
- On the HOLD -> IDLE transition, last_victim is set to victim_way and last_valid is set to 1.
- Ignored inputs:
  - fill_done outside HOLD.
  - req_valid outside IDLE.
  - rand outside SEL.
- Changes on the mask inputs after acceptance have no effect on the current selection.

## Timing
- Reset: state = IDLE, req_ready = 1, victim_valid = 0, victim_way = 0, victim_was_invalid = 0, victim_all_locked = 0, last_victim = 0, last_valid = 0.
- Request accepted at the edge ending cycle T:
  - SEL is cycle T+1.
  - victim_valid = 1 from cycle T+2.
  - req_ready = 0 from T+1 until the block is back in IDLE.
- While victim_valid = 1, victim_way and both flags are constant.
- fill_done sampled high in HOLD at cycle H:
  - From H+1: victim_valid = 0, req_ready = 1, and the victim outputs keep their last values.
  - The earliest next acceptance is at H+1, so back-to-back throughput is 1 request per 3 cycles minimum.
- rst asserted in any state: IDLE on the next cycle with all reset values. Repeat-avoidance history is cleared.
- req_ready is a decode of the state only. It has no combinational path from req_valid.

## Test plan
- Reset: apply rst for 2 cycles, then release.
  - Expect req_ready = 1, victim_valid = 0, victim_way = 0.
  - fill_done pulsed in IDLE leaves the state unchanged.
- Invalid way first (WAYS = 4): valid = 4'b1011, lock = 0, rand = 8'hFF.
  - Expect victim_way = 2 and victim_was_invalid = 1.
  - victim_valid rises exactly 2 cycles after acceptance.
- Random with repeat avoidance: valid = 4'hF, lock = 0.
  - First request with rand = 8'h05: expect way 1. Then fill_done.
  - Second request with rand = 8'h01: expect way 2.
- Lock skip: valid = 4'hF, lock = 4'b0110, last_valid = 0, rand = 8'h01.
  - Expect way 3 and victim_all_locked = 0.
- All locked: valid = 4'hF, lock = 4'hF, rand = 8'h02.
  - Expect way 2, victim_all_locked = 1, victim_was_invalid = 0.
- Reset mid-operation: assert rst while in HOLD with victim_way = 3.
  - Next cycle: victim_valid = 0, req_ready = 1, victim_way = 0.
  - A new request (valid = 4'hF, lock = 0, rand = 8'h03) yields way 3, since the history was cleared.
  - Holding mask inputs changing during SEL/HOLD produces no output change.
